// File: rtl/bram_dp_clear_block.sv
// ----------------------------------------------------------------------------
// bram_dp_clear_block
//
// True dual-port block RAM with a built-in hardware clear engine. After reset,
// and again whenever Clear_Req is pulsed while ready, the memory is zeroed one
// word per clock in ascending order. Port accesses are ignored while clearing.
//
// Ports:
//   BRAM_Clk            single clock shared by both ports
//   BRAM_Rst            asynchronous, active-high reset
//   BRAM_EN_A/B         port access enable
//   BRAM_WEN_A/B        byte-lane write enables, index 0 = data bits [0:7]
//   BRAM_Addr_A/B       byte address, highest index is the LSB
//   BRAM_Dout_A/B       write data coming from the master
//   BRAM_Din_A/B        read data returned to the master
//   Clear_Req           one-cycle request to zero the whole memory
//   Init_Done           high when the memory is cleared and ports are live
//   Collision           one-cycle pulse after both ports wrote the same word
// ----------------------------------------------------------------------------
module bram_dp_clear_block #(
    parameter int C_MEMSIZE     = 'h8000,
    parameter int C_PORT_DWIDTH = 32,
    parameter int C_PORT_AWIDTH = 32,
    parameter int C_NUM_WE      = C_PORT_DWIDTH / 8,
    parameter int C_OUTPUT_REG  = 0,
    parameter int C_WRITE_MODE  = 0
) (
    input  logic                     BRAM_Clk,
    input  logic                     BRAM_Rst,
    input  logic                     BRAM_EN_A,
    input  logic [0:C_NUM_WE-1]      BRAM_WEN_A,
    input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_A,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Din_A,
    input  logic                     BRAM_EN_B,
    input  logic [0:C_NUM_WE-1]      BRAM_WEN_B,
    input  logic [0:C_PORT_AWIDTH-1] BRAM_Addr_B,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Din_B,
    input  logic                     Clear_Req,
    output logic                     Init_Done,
    output logic                     Collision
);

    localparam int WORDS = C_MEMSIZE / C_NUM_WE;
    localparam int IDX_W = $clog2(WORDS);
    localparam int OFF_W = $clog2(C_NUM_WE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]               state;
    logic [IDX_W-1:0]         clr_cnt;
    logic                     ready;

    // Internally everything is handled as descending vectors. Copying the
    // ascending ports keeps the numeric value, so lane j here covers bits
    // [8j+7:8j] and is enabled by wen[j] (the master's WEN bit C_NUM_WE-1-j).
    logic [C_PORT_AWIDTH-1:0] addr_a, addr_b;
    logic [C_PORT_DWIDTH-1:0] dout_a, dout_b;
    logic [C_NUM_WE-1:0]      wen_a, wen_b;
    logic [IDX_W-1:0]         idx_a, idx_b;
    logic                     unused_addr;

    logic [C_PORT_DWIDTH-1:0] mem [WORDS];
    logic [C_PORT_DWIDTH-1:0] rd_next_a, rd_next_b;
    logic [C_PORT_DWIDTH-1:0] rd_a, rd_b;
    logic [C_PORT_DWIDTH-1:0] data_a, data_b;

    assign addr_a = BRAM_Addr_A;
    assign addr_b = BRAM_Addr_B;
    assign dout_a = BRAM_Dout_A;
    assign dout_b = BRAM_Dout_B;
    assign wen_a  = BRAM_WEN_A;
    assign wen_b  = BRAM_WEN_B;

    // Upper address bits are dropped on purpose so addresses wrap around.
    assign idx_a       = addr_a[OFF_W +: IDX_W];
    assign idx_b       = addr_b[OFF_W +: IDX_W];
    assign unused_addr = ^{addr_a, addr_b};

    assign ready     = (state == ST_READY);
    assign Init_Done = ready;

    function automatic logic [C_PORT_DWIDTH-1:0] merge_lanes(
        input logic [C_PORT_DWIDTH-1:0] old_word,
        input logic [C_PORT_DWIDTH-1:0] new_word,
        input logic [C_NUM_WE-1:0]      wen
    );
        logic [C_PORT_DWIDTH-1:0] result;
        result = old_word;
        for (int j = 0; j < C_NUM_WE; j++) begin
            if (wen[j]) result[8*j +: 8] = new_word[8*j +: 8];
        end
        return result;
    endfunction

    // Control FSM: reset always leads into a full clear, and the clear walks
    // the counter from word 0 up to the last word before opening the ports.
    always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
        if (BRAM_Rst) begin
            state   <= ST_RESET;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + IDX_W'(1);
                    if (clr_cnt == LAST_IDX) state <= ST_READY;
                end
                ST_READY: begin
                    if (Clear_Req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= ST_RESET;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // Memory array. Port B lanes are written first and port A lanes second,
    // so on a same-word collision overlapping lanes end up holding A's data
    // while non-overlapping lanes keep each port's own bytes.
    always_ff @(posedge BRAM_Clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (ready) begin
            if (BRAM_EN_B) begin
                for (int j = 0; j < C_NUM_WE; j++) begin
                    if (wen_b[j]) mem[idx_b][8*j +: 8] <= dout_b[8*j +: 8];
                end
            end
            if (BRAM_EN_A) begin
                for (int j = 0; j < C_NUM_WE; j++) begin
                    if (wen_a[j]) mem[idx_a][8*j +: 8] <= dout_a[8*j +: 8];
                end
            end
        end
    end

    // Write-first only folds in the port's own write; a write from the other
    // port in the same cycle is never visible to this port's read.
    always_comb begin
        rd_next_a = mem[idx_a];
        rd_next_b = mem[idx_b];
        if (C_WRITE_MODE != 0) begin
            rd_next_a = merge_lanes(mem[idx_a], dout_a, wen_a);
            rd_next_b = merge_lanes(mem[idx_b], dout_b, wen_b);
        end
    end

    // First read stage. Outside READY the registers are zeroed so the ports
    // come back showing 0 rather than stale pre-clear data.
    always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
        if (BRAM_Rst) begin
            rd_a <= '0;
            rd_b <= '0;
        end else if (!ready) begin
            rd_a <= '0;
            rd_b <= '0;
        end else begin
            if (BRAM_EN_A) rd_a <= rd_next_a;
            if (BRAM_EN_B) rd_b <= rd_next_b;
        end
    end

    // Optional output register; it only advances when the first stage was
    // loaded, so a disabled port keeps its last value on both latencies.
    generate
        if (C_OUTPUT_REG != 0) begin : g_out_reg
            logic [C_PORT_DWIDTH-1:0] out_a, out_b;
            logic                     en_a_d, en_b_d;

            always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
                if (BRAM_Rst) begin
                    out_a  <= '0;
                    out_b  <= '0;
                    en_a_d <= 1'b0;
                    en_b_d <= 1'b0;
                end else if (!ready) begin
                    out_a  <= '0;
                    out_b  <= '0;
                    en_a_d <= 1'b0;
                    en_b_d <= 1'b0;
                end else begin
                    en_a_d <= BRAM_EN_A;
                    en_b_d <= BRAM_EN_B;
                    if (en_a_d) out_a <= rd_a;
                    if (en_b_d) out_b <= rd_b;
                end
            end

            assign data_a = out_a;
            assign data_b = out_b;
        end else begin : g_no_out_reg
            assign data_a = rd_a;
            assign data_b = rd_b;
        end
    endgenerate

    // A read that completes together with a Clear_Req would otherwise be
    // visible during the first clear cycle; gating keeps Din at 0 there.
    assign BRAM_Din_A = ready ? data_a : '0;
    assign BRAM_Din_B = ready ? data_b : '0;

    // Same-word write conflict, registered so it pulses the following cycle.
    always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
        if (BRAM_Rst) begin
            Collision <= 1'b0;
        end else begin
            Collision <= ready && BRAM_EN_A && BRAM_EN_B && (|wen_a) && (|wen_b)
                         && (idx_a == idx_b);
        end
    end

endmodule

// File: tb/tb_bram_dp_clear_block.sv
// ----------------------------------------------------------------------------
// tb_bram_dp_clear_block
//
// Drives two copies of the block from the same stimulus: u0 is read-first
// with latency 1, u1 is write-first with an output register (latency 2).
// Read and collision expectations go into a scoreboard queue when a cycle is
// driven and are compared when the corresponding output is due.
// ----------------------------------------------------------------------------
module tb_bram_dp_clear_block;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [0:3]  wen_a = '0, wen_b = '0;
    logic [31:0] addr_a = '0, addr_b = '0;
    logic [31:0] dout_a = '0, dout_b = '0;
    logic        clear_req = 1'b0;
    logic [31:0] din_a0, din_b0, din_a1, din_b1;
    logic        init_done0, init_done1, collision0, collision1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        int          inst;
        int          port;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic        en_a;
        logic [0:3]  wen_a;
        logic [31:0] addr_a;
        logic [31:0] dout_a;
        logic        en_b;
        logic [0:3]  wen_b;
        logic [31:0] addr_b;
        logic [31:0] dout_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_col;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] mdl [16];
    logic [31:0] last_a0, last_b0, last_a1, last_b1;
    localparam int NV = 14;
    vec_t        vecs [NV];

    bram_dp_clear_block #(
        .C_MEMSIZE('h40), .C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4),
        .C_OUTPUT_REG(0), .C_WRITE_MODE(0)
    ) u0 (
        .BRAM_Clk(clk), .BRAM_Rst(rst),
        .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a),
        .BRAM_Dout_A(dout_a), .BRAM_Din_A(din_a0),
        .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b),
        .BRAM_Dout_B(dout_b), .BRAM_Din_B(din_b0),
        .Clear_Req(clear_req), .Init_Done(init_done0), .Collision(collision0)
    );

    bram_dp_clear_block #(
        .C_MEMSIZE('h40), .C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4),
        .C_OUTPUT_REG(1), .C_WRITE_MODE(1)
    ) u1 (
        .BRAM_Clk(clk), .BRAM_Rst(rst),
        .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a),
        .BRAM_Dout_A(dout_a), .BRAM_Din_A(din_a1),
        .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b),
        .BRAM_Dout_B(dout_b), .BRAM_Din_B(din_b1),
        .Clear_Req(clear_req), .Init_Done(init_done1), .Collision(collision1)
    );

    // 10 ns clock; cyc counts rising edges so scoreboard due times line up.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mergeW(input logic [31:0] old, input logic [31:0] nw, input logic [0:3] w);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (w[i]) r[31-8*i -: 8] = nw[31-8*i -: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] getActual(input int inst, input int port);
        if (inst == 0) begin
            if (port == 0) return din_a0;
            if (port == 1) return din_b0;
            return {31'b0, collision0};
        end
        if (port == 0) return din_a1;
        if (port == 1) return din_b1;
        return {31'b0, collision1};
    endfunction

    function automatic vec_t mk(input logic ea, input logic [0:3] wa, input logic [31:0] aa, input logic [31:0] da,
                                input logic eb, input logic [0:3] wb, input logic [31:0] ab, input logic [31:0] db,
                                input logic [31:0] xa, input logic [31:0] xb, input logic xc);
        vec_t v;
        v.en_a = ea; v.wen_a = wa; v.addr_a = aa; v.dout_a = da;
        v.en_b = eb; v.wen_b = wb; v.addr_b = ab; v.dout_b = db;
        v.exp_a = xa; v.exp_b = xb; v.exp_col = xc;
        return v;
    endfunction

    // Scoreboard checker: compares every entry that falls due this cycle.
    always @(negedge clk) begin
        string pn;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                pn = (sb[i].port == 0) ? "din_a" : (sb[i].port == 1) ? "din_b" : "collision";
                checkOutput($sformatf("u%0d_%s_cyc%0d", sb[i].inst, pn, cyc),
                            getActual(sb[i].inst, sb[i].port), sb[i].val);
                sb.delete(i);
            end
        end
    end

    function automatic void pushExp(input int due, input int inst, input int port, input logic [31:0] val);
        exp_t e;
        e.due = due; e.inst = inst; e.port = port; e.val = val;
        sb.push_back(e);
    endfunction

    function automatic void zeroModel();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        last_a0 = '0; last_b0 = '0; last_a1 = '0; last_b1 = '0;
    endfunction

    // Drives one READY-state cycle and queues what both copies must return.
    // u0 expectations come from the vector table when use_tab is set,
    // otherwise from the read-first model; u1 always from the write-first model.
    task automatic applyStimulus(input vec_t v, input bit use_tab);
        int          ia, ib;
        logic [31:0] old_a, old_b, ea0, eb0, ea1, eb1;
        logic        col;
        @(posedge clk);
        #1;
        en_a = v.en_a; wen_a = v.wen_a; addr_a = v.addr_a; dout_a = v.dout_a;
        en_b = v.en_b; wen_b = v.wen_b; addr_b = v.addr_b; dout_b = v.dout_b;
        ia = int'(v.addr_a[5:2]);
        ib = int'(v.addr_b[5:2]);
        old_a = mdl[ia];
        old_b = mdl[ib];
        col = v.en_a && v.en_b && (|v.wen_a) && (|v.wen_b) && (ia == ib);
        ea0 = use_tab ? v.exp_a : (v.en_a ? old_a : last_a0);
        eb0 = use_tab ? v.exp_b : (v.en_b ? old_b : last_b0);
        ea1 = v.en_a ? mergeW(old_a, v.dout_a, v.wen_a) : last_a1;
        eb1 = v.en_b ? mergeW(old_b, v.dout_b, v.wen_b) : last_b1;
        pushExp(cyc + 1, 0, 0, ea0);
        pushExp(cyc + 1, 0, 1, eb0);
        pushExp(cyc + 1, 0, 2, use_tab ? {31'b0, v.exp_col} : {31'b0, col});
        pushExp(cyc + 2, 1, 0, ea1);
        pushExp(cyc + 2, 1, 1, eb1);
        pushExp(cyc + 1, 1, 2, {31'b0, col});
        if (v.en_a) last_a0 = old_a;
        if (v.en_b) last_b0 = old_b;
        last_a1 = ea1;
        last_b1 = eb1;
        if (v.en_b) mdl[ib] = mergeW(mdl[ib], v.dout_b, v.wen_b);
        if (v.en_a) mdl[ia] = mergeW(mdl[ia], v.dout_a, v.wen_a);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            en_a = 0; en_b = 0; wen_a = '0; wen_b = '0; clear_req = 0;
        end
    endtask

    // Called right after the edge that entered CLEAR: counts edges until
    // Init_Done rises. With noise set, it keeps hammering both ports and
    // re-pulses Clear_Req, none of which may have any effect.
    task automatic countClear(input string tag, input bit noise);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (init_done0) break;
            if (n % 4 == 1) begin
                checkOutput({tag, "_din_a0_zero"}, din_a0, 32'h0);
                checkOutput({tag, "_din_a1_zero"}, din_a1, 32'h0);
            end
            if (noise) begin
                en_a = 1; wen_a = 4'b1111; addr_a = 32'h14; dout_a = 32'hFFFFFFFF;
                en_b = 1; wen_b = 4'b0000; addr_b = 32'h14;
                clear_req = (n == 5);
            end
        end
        en_a = 0; en_b = 0; wen_a = '0; wen_b = '0; clear_req = 0;
        checkOutput({tag, "_cycles"}, n, 32'd16);
        checkOutput({tag, "_init_done1"}, {31'b0, init_done1}, 32'h1);
        zeroModel();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Hand-derived vectors for u0 (read-first, latency 1), memory all zero.
        vecs[0]  = mk(1, 4'b1111, 32'h08, 32'h11223344, 0, 4'b0000, 32'h00, 32'h0,        32'h0,        32'h0,        0);
        vecs[1]  = mk(1, 4'b0000, 32'h08, 32'h0,        0, 4'b0000, 32'h00, 32'h0,        32'h11223344, 32'h0,        0);
        vecs[2]  = mk(1, 4'b1100, 32'h04, 32'hAAAAAAAA, 1, 4'b0110, 32'h04, 32'hBBBBBBBB, 32'h0,        32'h0,        1);
        vecs[3]  = mk(1, 4'b0000, 32'h04, 32'h0,        1, 4'b0000, 32'h08, 32'h0,        32'hAAAABB00, 32'h11223344, 0);
        vecs[4]  = mk(1, 4'b1111, 32'h0C, 32'h7,        0, 4'b0000, 32'h00, 32'h0,        32'h0,        32'h11223344, 0);
        vecs[5]  = mk(1, 4'b1111, 32'h0C, 32'h5,        0, 4'b0000, 32'h00, 32'h0,        32'h7,        32'h11223344, 0);
        vecs[6]  = mk(1, 4'b0000, 32'h0C, 32'h0,        1, 4'b1111, 32'h0C, 32'h12345678, 32'h5,        32'h5,        0);
        vecs[7]  = mk(0, 4'b0000, 32'h00, 32'h0,        1, 4'b0000, 32'h4C, 32'h0,        32'h5,        32'h12345678, 0);
        vecs[8]  = mk(1, 4'b0001, 32'h10, 32'hCAFEBAEE, 1, 4'b1000, 32'h10, 32'h99887766, 32'h0,        32'h0,        1);
        vecs[9]  = mk(1, 4'b0000, 32'h10, 32'h0,        1, 4'b0000, 32'h50, 32'h0,        32'h990000EE, 32'h990000EE, 0);
        vecs[10] = mk(1, 4'b1111, 32'h40, 32'hFFFFFFFF, 0, 4'b0000, 32'h00, 32'h0,        32'h0,        32'h990000EE, 0);
        vecs[11] = mk(1, 4'b0000, 32'h00, 32'h0,        1, 4'b0000, 32'h80, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        vecs[12] = mk(0, 4'b1111, 32'h00, 32'h0,        0, 4'b0000, 32'h00, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        vecs[13] = mk(1, 4'b0000, 32'h00, 32'h0,        0, 4'b0000, 32'h00, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        zeroModel();

        // Reset state, then the power-up clear.
        repeat (3) @(negedge clk);
        checkOutput("rst_init_done0", {31'b0, init_done0}, 32'h0);
        checkOutput("rst_din_a0", din_a0, 32'h0);
        checkOutput("rst_din_b1", din_b1, 32'h0);
        checkOutput("rst_collision0", {31'b0, collision0}, 32'h0);
        @(posedge clk);
        #3 rst = 0;
        @(posedge clk);
        countClear("clear_powerup", 0);

        // Every word must read back zero on both ports.
        for (int w = 0; w < 16; w++)
            applyStimulus(mk(1, 4'b0000, w * 4, 32'h0, 1, 4'b0000, (15 - w) * 4, 32'h0, 0, 0, 0), 0);
        idle(3);

        // Table-driven accesses.
        for (int i = 0; i < NV; i++) applyStimulus(vecs[i], 1);
        idle(3);

        // Clear request while a word holds data; the coinciding write completes.
        applyStimulus(mk(1, 4'b1111, 32'h14, 32'hDEADBEEF, 0, 4'b0000, 0, 0, 0, 0, 0), 0);
        applyStimulus(mk(1, 4'b0000, 32'h14, 32'h0, 0, 4'b0000, 0, 0, 0, 0, 0), 0);
        idle(3);
        @(posedge clk);
        #1;
        en_a = 1; wen_a = 4'b1111; addr_a = 32'h18; dout_a = 32'h01020304; clear_req = 1;
        @(posedge clk);
        #1;
        en_a = 0; wen_a = '0; clear_req = 0;
        checkOutput("clr_init_fall", {31'b0, init_done0}, 32'h0);
        countClear("clear_req", 1);
        applyStimulus(mk(1, 4'b0000, 32'h14, 32'h0, 1, 4'b0000, 32'h18, 32'h0, 0, 0, 0), 0);
        idle(3);

        // Reset in the middle of a clear restarts it from word 0.
        applyStimulus(mk(1, 4'b1111, 32'h30, 32'hC0C0C0C0, 0, 4'b0000, 0, 0, 0, 0, 0), 0);
        idle(3);
        @(posedge clk);
        #1 clear_req = 1;
        @(posedge clk);
        #1 clear_req = 0;
        repeat (9) @(posedge clk);
        #2 rst = 1;
        #1;
        checkOutput("midclr_rst_init", {31'b0, init_done0}, 32'h0);
        checkOutput("midclr_rst_col", {31'b0, collision1}, 32'h0);
        @(posedge clk);
        #3 rst = 0;
        @(posedge clk);
        #1 checkOutput("midclr_entry_init", {31'b0, init_done1}, 32'h0);
        countClear("clear_after_rst", 0);
        applyStimulus(mk(1, 4'b0000, 32'h40, 32'h0, 1, 4'b0000, 32'h30, 32'h0, 0, 0, 0), 0);
        idle(3);

        // Asynchronous reset while READY with nonzero read data on the ports.
        applyStimulus(mk(1, 4'b1111, 32'h08, 32'h5A5A5A5A, 0, 4'b0000, 0, 0, 0, 0, 0), 0);
        applyStimulus(mk(1, 4'b0000, 32'h08, 32'h0, 0, 4'b0000, 0, 0, 0, 0, 0), 0);
        idle(4);
        @(negedge clk);
        rst = 1;
        #1;
        checkOutput("async_rst_din_a0", din_a0, 32'h0);
        checkOutput("async_rst_din_a1", din_a1, 32'h0);
        checkOutput("async_rst_init0", {31'b0, init_done0}, 32'h0);
        checkOutput("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
